elbeth_dmem_responder: RTL and testbench
========================================

// Module: elbeth_dmem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port. Answers exs_dmem_en requests with a
//  one-cycle dmem_ready pulse after a fixed latency; serves byte/half/word loads and stores
//  against an internal word-organised RAM. Flags misaligned and faulting accesses; those flags
//  drive the control unit's exs_except_from_mem input.
// PARAMETERS
//  MEM_WORDS   1024          RAM depth in 32-bit words
//  BASE_ADDR   32'h0000_0000 byte address of word 0
//  LATENCY     2             cycles from accept to ready for valid accesses (legal range 1..15)
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous active-high reset
//  dmem_en          in   1   request valid; core holds it and all request fields until ready
//  dmem_rw          in   1   0 read, 1 write
//  dmem_addr        in   32  byte address
//  dmem_funct3      in   3   0 B, 1 H, 2 W, 4 BU, 5 HU (RV32 load/store funct3)
//  dmem_wdata       in   32  store data, right-aligned (low byte/half/word)
//  dmem_rdata       out  32  load data, extended per funct3; held until the next read response
//  dmem_ready       out  1   one-cycle response pulse
//  dmem_misaligned  out  1   valid only with ready: misaligned access
//  dmem_fault       out  1   valid only with ready: address out of range or illegal funct3
// BEHAVIOUR
//  - Reset: state IDLE, counter 0; ready, misaligned, fault and rdata all 0; RAM not cleared.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. IDLE with dmem_en=1 accepts: latch rw, addr, funct3, wdata.
//  - Error check at accept:
//    - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
//    - Fault: addr<BASE_ADDR, addr>=BASE_ADDR+4*MEM_WORDS, funct3 in {3,6,7}, or rw=1 with funct3>2.
//    - Misaligned takes priority over fault.
//  - Error: go straight to RESP; ready and flag asserted in cycle t+1 (t = accept cycle).
//    No RAM write; rdata unchanged.
//  - Valid access: WAIT counts LATENCY-1 cycles; RESP asserts ready in cycle t+LATENCY.
//    LATENCY=1 skips WAIT.
//  - Write: committed to RAM only in the RESP cycle. Byte enables: B -> 1<<addr[1:0];
//    H -> 2'b11<<addr[1:0]; W -> 4'hF. wdata is lane-replicated to the addressed bytes.
//  - Read: RAM word is read at accept+1. Lane selected by addr[1:0]; sign-extended for B/H,
//    zero-extended for BU/HU. dmem_rdata registered so it is valid in the ready cycle.
//  - After RESP the FSM always returns to IDLE, so back-to-back requests are accepted the
//    cycle after ready (minimum one idle cycle between responses).
//  - Abort: dmem_en=0 while in WAIT (pipeline flush) -> return to IDLE next cycle.
//    No ready, no write, no flags.
//  - Request fields changing during WAIT are ignored; only the latched copy is used.
//  - rst asserted mid-operation -> IDLE next cycle; a pending write is dropped.
//  - Address index = (addr-BASE_ADDR)>>2, truncated to clog2(MEM_WORDS) bits after the range check.
// STRUCTURE
//  - elbeth_definitions.v holds the shared constants: funct3 size codes (F3_LB/LH/LW/LBU/LHU,
//    F3_SB/SH/SW) and the responder FSM state encodings.
//  - One sub-module: elbeth_dmem_lane_align, combinational. Inputs: addr[1:0], funct3, wdata,
//    RAM word. Outputs: byte enables, shifted write data, extended read data.
//  - RAM is an inferred reg array with per-byte write enable.
// TESTING
//  1. Reset, then SW addr=0x10 data=0xDEADBEEF; LW 0x10 -> ready at t+2, rdata=0xDEADBEEF,
//     both flags 0.
//  2. SB 0x13 data=0x80; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
//  3. LW 0x12 -> ready at t+1, misaligned=1, rdata unchanged. SH 0x11 -> misaligned=1,
//     word 0x10 unchanged.
//  4. LW BASE_ADDR+4*MEM_WORDS -> fault=1 at t+1. Store with funct3=4 -> fault=1, no write.
//  5. SW 0x20 data=0x1234; drop en in the cycle after accept -> no ready;
//     LW 0x20 returns the prior contents.
//  6. Hold en high over two consecutive requests with LATENCY=3 -> ready at t+3;
//     second accepted at t+4; ready at t+7. rst during WAIT -> ready never asserts.

Source files
------------

// File: rtl/elbeth_dmem_responder_pkg.sv
// Shared constants for the data-memory responder: funct3 size codes, FSM states
// and the access-legality helpers used at request accept.
package elbeth_dmem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic result;
        result = 1'b0;
        if (funct3 == F3_LH || funct3 == F3_LHU)
            result = addr_lo[0];
        else if (funct3 == F3_LW)
            result = (addr_lo != 2'b00);
        return result;
    endfunction

    // Stores only exist as B/H/W, so any funct3 above W is illegal for a write.
    function automatic logic is_bad_funct3(input logic rw, input logic [2:0] funct3);
        return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7) ||
               (rw && (funct3 > F3_SW));
    endfunction

endpackage

// File: rtl/elbeth_dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated write data,
// plus lane selection and sign/zero extension of the loaded word.
module elbeth_dmem_lane_align
    import elbeth_dmem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        shifted   = rword >> {addr_lo, 3'b000};
        byte_s    = signed'(shifted[7:0]);
        half_s    = signed'(shifted[15:0]);
        be        = 4'b0000;
        wdata_sh  = wdata;
        rdata_ext = rword;
        case (funct3)
            F3_LB: begin
                be        = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = 32'(byte_s);
            end
            F3_LH: begin
                be        = 4'b0011 << addr_lo;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = 32'(half_s);
            end
            F3_LW: begin
                be        = 4'b1111;
                rdata_ext = rword;
            end
            F3_LBU: rdata_ext = {24'd0, shifted[7:0]};
            F3_LHU: rdata_ext = {16'd0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/elbeth_dmem_responder.sv
// Data-memory responder: accepts one request at a time, answers with a one-cycle
// ready pulse after LATENCY cycles (or next cycle for misaligned/faulting accesses).
module elbeth_dmem_responder
    import elbeth_dmem_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_en,
    input  logic        dmem_rw,
    input  logic [31:0] dmem_addr,
    input  logic [2:0]  dmem_funct3,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        dmem_misaligned,
    output logic        dmem_fault
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    logic [31:0] mem [MEM_WORDS];

    resp_state_t state;
    logic [3:0]  cnt;
    logic        rw_p0;
    logic        err_p0;
    logic [2:0]  f3_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;

    logic             cur_rw;
    logic [2:0]       cur_f3;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [IDX_W-1:0] cur_idx;
    logic             mis_c;
    logic             fault_c;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic [31:0]      rd_ext;

    // In IDLE the live request is decoded; afterwards only the latched copy counts.
    always_comb begin
        cur_rw    = rw_p0;
        cur_f3    = f3_p0;
        cur_addr  = addr_p0;
        cur_wdata = wdata_p0;
        if (state == ST_IDLE) begin
            cur_rw    = dmem_rw;
            cur_f3    = dmem_funct3;
            cur_addr  = dmem_addr;
            cur_wdata = dmem_wdata;
        end
        cur_idx = IDX_W'((cur_addr - BASE_ADDR) >> 2);
        mis_c   = is_misaligned(cur_f3, cur_addr[1:0]);
        fault_c = (cur_addr < BASE_ADDR) || ({1'b0, cur_addr} >= END_ADDR) ||
                  is_bad_funct3(cur_rw, cur_f3);
    end

    elbeth_dmem_lane_align u_lane_align (
        .addr_lo   (cur_addr[1:0]),
        .funct3    (cur_f3),
        .wdata     (cur_wdata),
        .rword     (mem[cur_idx]),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rd_ext)
    );

    // p0: request capture at accept
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && dmem_en) begin
            rw_p0    <= dmem_rw;
            f3_p0    <= dmem_funct3;
            addr_p0  <= dmem_addr;
            wdata_p0 <= dmem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            cnt             <= 4'd0;
            err_p0          <= 1'b0;
            dmem_ready      <= 1'b0;
            dmem_misaligned <= 1'b0;
            dmem_fault      <= 1'b0;
            dmem_rdata      <= 32'd0;
        end else begin
            dmem_ready      <= 1'b0;
            dmem_misaligned <= 1'b0;
            dmem_fault      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dmem_en) begin
                        err_p0 <= mis_c || fault_c;
                        cnt    <= 4'd0;
                        if (mis_c || fault_c) begin
                            state           <= ST_RESP;
                            dmem_ready      <= 1'b1;
                            dmem_misaligned <= mis_c;
                            dmem_fault      <= !mis_c && fault_c;
                        end else if (LATENCY == 1) begin
                            state      <= ST_RESP;
                            dmem_ready <= 1'b1;
                            if (!dmem_rw)
                                dmem_rdata <= rd_ext;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!dmem_en) begin
                        state <= ST_IDLE;
                    end else if (cnt == WAIT_LAST) begin
                        state      <= ST_RESP;
                        dmem_ready <= 1'b1;
                        if (!rw_p0)
                            dmem_rdata <= rd_ext;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // p1: store commit happens only on the response cycle of a legal write
    always_ff @(posedge clk) begin
        if (!rst && state == ST_RESP && rw_p0 && !err_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[cur_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_elbeth_dmem_responder.sv
// Directed bench for the data-memory responder: a LATENCY=2 instance for the
// functional sequence and a LATENCY=3 instance for held-enable and reset cases.
module tb_elbeth_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] wdata = 32'd0;

    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, mis_a, mis_b, fault_a, fault_b;

    logic        sel = 1'b0;
    logic        sel_ready, sel_mis, sel_fault;
    logic [31:0] sel_rdata;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        flt;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    assign sel_ready = sel ? ready_b : ready_a;
    assign sel_mis   = sel ? mis_b   : mis_a;
    assign sel_fault = sel ? fault_b : fault_a;
    assign sel_rdata = sel ? rdata_b : rdata_a;

    elbeth_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .dmem_en(en_a), .dmem_rw(rw), .dmem_addr(addr),
        .dmem_funct3(funct3), .dmem_wdata(wdata), .dmem_rdata(rdata_a),
        .dmem_ready(ready_a), .dmem_misaligned(mis_a), .dmem_fault(fault_a)
    );

    elbeth_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .dmem_en(en_b), .dmem_rw(rw), .dmem_addr(addr),
        .dmem_funct3(funct3), .dmem_wdata(wdata), .dmem_rdata(rdata_b),
        .dmem_ready(ready_b), .dmem_misaligned(mis_b), .dmem_fault(fault_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input logic v);
        if (sel) en_b = v;
        else     en_a = v;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!sel_ready && n < 20);
    endtask

    task automatic run_req(input string tag, input logic rw_i, input logic [31:0] a,
                           input logic [2:0] f, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic em, input logic ef,
                           input int lat);
        exp_t e;
        int   n;
        exp_q.push_back('{rd: exp_rd, mis: em, flt: ef, lat: lat});
        @(negedge clk);
        rw = rw_i; addr = a; funct3 = f; wdata = wd;
        set_en(1'b1);
        wait_ready(n);
        set_en(1'b0);
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(n), 32'(e.lat));
        check({tag, "_rdata"}, sel_rdata, e.rd);
        check({tag, "_misaligned"}, {31'd0, sel_mis}, {31'd0, e.mis});
        check({tag, "_fault"}, {31'd0, sel_fault}, {31'd0, e.flt});
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, sel_ready}, 32'd0);
    endtask

    initial begin
        int   n;
        logic seen;
        exp_t e;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready_a}, 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_mis", {31'd0, mis_a}, 32'd0);
        check("rst_fault", {31'd0, fault_a}, 32'd0);
        check("rst_ready_b", {31'd0, ready_b}, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_req("sw10",   1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 2);
        run_req("lw10",   1'b0, 32'h10, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2);

        run_req("sb13",   1'b1, 32'h13, 3'd0, 32'h80,       32'hDEADBEEF, 1'b0, 1'b0, 2);
        run_req("lb13",   1'b0, 32'h13, 3'd0, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 2);
        run_req("lbu13",  1'b0, 32'h13, 3'd4, 32'h0,        32'h00000080, 1'b0, 1'b0, 2);
        run_req("lw10b",  1'b0, 32'h10, 3'd2, 32'h0,        32'h80ADBEEF, 1'b0, 1'b0, 2);
        run_req("lh12",   1'b0, 32'h12, 3'd1, 32'h0,        32'hFFFF80AD, 1'b0, 1'b0, 2);
        run_req("lhu12",  1'b0, 32'h12, 3'd5, 32'h0,        32'h000080AD, 1'b0, 1'b0, 2);

        run_req("lw12mis", 1'b0, 32'h12, 3'd2, 32'h0,       32'h000080AD, 1'b1, 1'b0, 1);
        run_req("sh11mis", 1'b1, 32'h11, 3'd1, 32'hFFFF,    32'h000080AD, 1'b1, 1'b0, 1);
        run_req("lw10c",  1'b0, 32'h10, 3'd2, 32'h0,        32'h80ADBEEF, 1'b0, 1'b0, 2);

        run_req("lwoor",  1'b0, 32'h1000, 3'd2, 32'h0,      32'h80ADBEEF, 1'b0, 1'b1, 1);
        run_req("misprio", 1'b0, 32'h1002, 3'd2, 32'h0,     32'h80ADBEEF, 1'b1, 1'b0, 1);
        run_req("sbu",    1'b1, 32'h10, 3'd4, 32'hFF,       32'h80ADBEEF, 1'b0, 1'b1, 1);
        run_req("f3bad",  1'b0, 32'h10, 3'd3, 32'h0,        32'h80ADBEEF, 1'b0, 1'b1, 1);
        run_req("lw10d",  1'b0, 32'h10, 3'd2, 32'h0,        32'h80ADBEEF, 1'b0, 1'b0, 2);
        run_req("swtop",  1'b1, 32'hFFC, 3'd2, 32'h5A5A1234, 32'h80ADBEEF, 1'b0, 1'b0, 2);
        run_req("lwtop",  1'b0, 32'hFFC, 3'd2, 32'h0,       32'h5A5A1234, 1'b0, 1'b0, 2);
        run_req("sh12",   1'b1, 32'h12, 3'd1, 32'h1234,     32'h5A5A1234, 1'b0, 1'b0, 2);
        run_req("lw10e",  1'b0, 32'h10, 3'd2, 32'h0,        32'h1234BEEF, 1'b0, 1'b0, 2);
        run_req("lb11",   1'b0, 32'h11, 3'd0, 32'h0,        32'hFFFFFFBE, 1'b0, 1'b0, 2);

        // Aborted store: enable drops in the cycle after accept
        run_req("sw20",   1'b1, 32'h20, 3'd2, 32'h11111111, 32'hFFFFFFBE, 1'b0, 1'b0, 2);
        @(negedge clk);
        rw = 1'b1; addr = 32'h20; funct3 = 3'd2; wdata = 32'h00001234; en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready_a) seen = 1'b1;
        end
        check("abort_no_ready", {31'd0, seen}, 32'd0);
        run_req("lw20",   1'b0, 32'h20, 3'd2, 32'h0,        32'h11111111, 1'b0, 1'b0, 2);

        // LATENCY=3 instance, enable held across two back-to-back requests
        sel = 1'b1;
        exp_q.push_back('{rd: 32'h0, mis: 1'b0, flt: 1'b0, lat: 3});
        exp_q.push_back('{rd: 32'hCAFEF00D, mis: 1'b0, flt: 1'b0, lat: 4});
        @(negedge clk);
        rw = 1'b1; addr = 32'h40; funct3 = 3'd2; wdata = 32'hCAFEF00D; en_b = 1'b1;
        wait_ready(n);
        e = exp_q.pop_front();
        check("hold_first_latency", 32'(n), 32'(e.lat));
        check("hold_first_rdata", rdata_b, e.rd);
        rw = 1'b0;
        wait_ready(n);
        en_b = 1'b0;
        e = exp_q.pop_front();
        check("hold_second_gap", 32'(n), 32'(e.lat));
        check("hold_second_rdata", rdata_b, e.rd);
        @(posedge clk); #1;

        // Reset while a store waits: no response and the store is dropped
        @(negedge clk);
        rw = 1'b1; addr = 32'h40; funct3 = 3'd2; wdata = 32'h0; en_b = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; en_b = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_wait_rdata", rdata_b, 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready_b) seen = 1'b1;
        end
        check("rst_wait_no_ready", {31'd0, seen}, 32'd0);
        run_req("lw40",   1'b0, 32'h40, 3'd2, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
